// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam state_e ST_RESET = IDLE;

    // One extra bit so the counter can never wrap before the last bit is processed.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/half_adder_d.sv
// One-bit half adder: the basic datapath cell the serial adder is built on.
module half_adder_d (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational full adder from two half adders; the carry flop lives in the sequencer.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0, c0, c1;

    half_adder_d u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder_d u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts a/b, adds LSB-first one bit per clock,
// and presents {cout,sum} over a valid/ready handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r;
    logic             fa_s, fa_c;
    logic [WIDTH:0]   sum_ext;

    serial_fa_cell u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_c)
    );

    // New sum bit enters at the MSB; written this way so WIDTH==1 needs no special case.
    assign sum_ext = {fa_s, sum_r};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RESET;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        sum_r <= '0;
                        cnt   <= '0;
                        carry <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= sum_ext[WIDTH:1];
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout_r <= fa_c;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=4.
module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int passed = 0;
    int total  = 0;
    logic [W:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Drives one operand pair, pushes the expected result, waits for the result.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         output logic [W:0] got, output logic [W:0] ex,
                         output int lat, output logic rdy_after);
        @(negedge clk);
        a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back({1'b0, ta} + {1'b0, tb});
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = {cout, sum};
        ex  = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        @(negedge clk);
        rdy_after = in_ready && !out_valid;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, sum, cout, busy} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL reset_outputs got=%b want=%b",
                     {in_ready, out_valid, sum, cout, busy}, 8'b1000_0000);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
        else passed++;
    endtask

    task automatic test_basic;
        logic [W:0] got, ex;
        int lat;
        logic rdy;
        do_op(4'd3, 4'd5, got, ex, lat, rdy);
        total++;
        if (lat !== 4) $display("FAIL basic_latency got=%0d want=4", lat); else passed++;
        total++;
        if (got !== ex || ex !== 5'd8) $display("FAIL basic_sum got=%0d want=%0d", got, ex);
        else passed++;
        total++;
        if (rdy !== 1'b1) $display("FAIL basic_in_ready_after got=%b want=1", rdy); else passed++;
    endtask

    task automatic test_overflow;
        logic [W-1:0] av[3] = '{4'd15, 4'd9, 4'd0};
        logic [W-1:0] bv[3] = '{4'd1,  4'd7, 4'd0};
        logic [W:0]   want[3] = '{5'b1_0000, 5'b1_0000, 5'b0_0000};
        logic [W:0] got, ex;
        int lat;
        logic rdy;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], got, ex, lat, rdy);
            total++;
            if (got !== ex || ex !== want[i])
                $display("FAIL overflow_%0d got=%b want=%b", i, got, want[i]);
            else passed++;
            total++;
            if (lat !== 4) $display("FAIL overflow_lat_%0d got=%0d want=4", i, lat); else passed++;
        end
    endtask

    task automatic test_backpressure;
        int lat = 0;
        logic [W:0] ex;
        out_ready = 1'b0;
        @(negedge clk);
        a = 4'd6; b = 4'd6; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(5'd12);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({out_valid, busy, in_ready, cout, sum} !== {1'b1, 1'b1, 1'b0, ex})
                $display("FAIL backpressure_hold_%0d got=%b want=%b",
                         i, {out_valid, busy, in_ready, cout, sum}, {3'b110, ex});
            else passed++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL backpressure_release got=%b want=100", {in_ready, out_valid, busy});
        else passed++;
    endtask

    task automatic test_isolation;
        int lat = 0;
        logic [W:0] got, ex;
        @(negedge clk);
        a = 4'd2; b = 4'd2; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(5'd4);
        @(negedge clk);
        a = 4'd15; b = 4'd15;
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 2;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = {cout, sum};
        ex  = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (got !== ex) $display("FAIL isolation_sum got=%0d want=%0d", got, ex); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({busy, in_ready} !== 2'b01)
            $display("FAIL isolation_no_second_accept got=%b want=01", {busy, in_ready});
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        logic [W:0] got, ex;
        int lat;
        logic rdy;
        @(negedge clk);
        a = 4'd10; b = 4'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, sum, cout, busy} !== 8'b1000_0000)
            $display("FAIL midrun_reset got=%b want=10000000",
                     {in_ready, out_valid, sum, cout, busy});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd1, 4'd1, got, ex, lat, rdy);
        total++;
        if (got !== ex || ex !== 5'd2) $display("FAIL midrun_next got=%0d want=2", got);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int acc = 0, got_n = 0, cyc = 0, last = -1;
        logic [W:0] ex;
        logic [W-1:0] ra, rb;
        while (got_n < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                ex = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total++;
                if ({cout, sum} !== ex)
                    $display("FAIL b2b_result_%0d got=%0d want=%0d", got_n, {cout, sum}, ex);
                else passed++;
                got_n++;
            end
            if (in_ready) begin
                if (acc < 8) begin
                    ra = W'($urandom_range(0, 15));
                    rb = W'($urandom_range(0, 15));
                    a = ra; b = rb; in_valid = 1'b1;
                    exp_q.push_back({1'b0, ra} + {1'b0, rb});
                    if (last >= 0) begin
                        total++;
                        if (cyc - last !== 6)
                            $display("FAIL b2b_interval got=%0d want=6", cyc - last);
                        else passed++;
                    end
                    last = cyc;
                    acc++;
                end else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total++;
        if (got_n !== 8) $display("FAIL b2b_count got=%0d want=8", got_n); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_isolation();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
